dmem_access_unit: RTL and testbench
===================================

# dmem_access_unit

Data-memory access sequencer for the single-issue MIPS core. It sits between the decode/execute stage and the external data bus. It takes the 2-bit MemRead/MemWrite size codes produced by the control decoder (00 none, 01 byte, 10 half, 11 word), runs a req/ack transaction on a word-wide bus, and steers byte lanes. It also sign-extends load data and stalls the pipeline until the access completes.

## Interface
Parameters:
- TIMEOUT, default 15: bus cycles without `bus_ack` before the access is aborted (1..255).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `MemRead` input 2: load size code (00 none, 01 lb, 10 lh, 11 lw).
- `MemWrite` input 2: store size code (00 none, 01 sb, 10 sh, 11 sw).
- `addr` input 32: byte address from the ALU.
- `wdata` input 32: store data (rt).
- `rdata` output 32: sign-extended load result, registered.
- `stall` output 1: holds the pipeline; upstream keeps all inputs stable while it is high.
- `done` output 1: one-cycle pulse when the access completes.
- `misalign` output 1: one-cycle pulse with `done` on a misaligned access (see Configuration).
- `timeout_err` output 1: sticky until reset.
- `bus_req` output 1, `bus_we` output 1, `bus_addr` output 32 (bits [1:0] = 0), `bus_be` output 4, `bus_wdata` output 32.
- `bus_ack` input 1, `bus_rdata` input 32.

## Operation
States:
- **IDLE**
  - If `MemWrite`≠0, latch a store; else if `MemRead`≠0, latch a load. Then go to REQ. Write has priority if both codes are nonzero.
  - With no request, stay in IDLE.
- **REQ**
  - `bus_req`=1 and all bus_* outputs are held constant.
  - On `bus_ack`=1, capture `bus_rdata` (loads) and go to DONE.
  - Otherwise increment the wait counter. When the count reaches TIMEOUT, go to ERR.
- **DONE**
  - `done`=1 and `stall`=0.
  - Next state is always IDLE. The request still visible on the inputs in this cycle is not restarted.
- **ERR**
  - `bus_req`=0, `timeout_err` is set, `rdata`=0, `done`=1, `stall`=0.
  - Next state is IDLE.

Lane rules (little-endian, k=`addr[1:0]`):
- Byte
  - Store: `bus_be`=0001<<k, `bus_wdata`={4{wdata[7:0]}}.
  - Load: `rdata`=sext(`bus_rdata`[8k+7:8k]).
- Half
  - Store: `bus_be`=0011<<(2·`addr[1]`), `bus_wdata`={2{wdata[15:0]}}.
  - Load: `rdata`=sext of the selected half.
- Word
  - Store: `bus_be`=1111, `bus_wdata`=`wdata`.
  - Load: `rdata`=`bus_rdata`.

Other rules:
- `bus_be` is valid on loads too. The bus ignores it on reads.
- `bus_addr`={addr[31:2],2'b00}.
- `stall` is combinational: 1 in IDLE with a request pending, 1 in REQ, 0 otherwise.
- `bus_ack` outside REQ is ignored.
- `rdata` holds its last value until the next completed load or ERR. Stores do not modify `rdata`.
- `rst_n` low in any state: return to IDLE immediately with the counter cleared. An in-flight bus cycle is abandoned: `bus_req` drops asynchronously.

## Timing
- Reset values: all outputs 0. This includes `rdata`, `timeout_err`, `bus_addr`, `bus_be`, `bus_wdata` and `bus_we`.
- Request visible at edge 0 (IDLE). `bus_req` is high after edge 1.
- If ack arrives in the first REQ cycle, `done` is high after edge 2 and `stall` falls in the same cycle.
- Minimum latency is 2 cycles. Latency is 2+N cycles for N wait cycles.
- Timeout: `bus_req` is high for exactly TIMEOUT cycles without ack, then the unit is in ERR for 1 cycle.
- Ack in the same cycle that the counter hits TIMEOUT: the ack wins, the access completes normally and there is no error.
- Back-to-back accesses: the new request is accepted in the IDLE cycle after DONE. The throughput floor is 3 cycles per access.

## Configuration
Macro: `DMEM_MISALIGN_TRAP_EN`.
- **Defined:**
  - A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, is misaligned.
  - A misaligned access issues no bus transaction. The unit goes IDLE→DONE directly with `misalign`=1 and `rdata` unchanged.
  - Latency is 1 cycle.
- **Undefined:**
  - `misalign` is tied to 0.
  - Half accesses ignore `addr[0]`. Word accesses ignore `addr[1:0]`.
  - All accesses go to the bus.

## Test plan
- lb at addr 0x00000103, bus_rdata 0x80FF1234, ack in the first REQ cycle -> `rdata`=0xFFFFFF80, `done` after 2 cycles, `stall` high for 2 cycles.
- sh at addr 0x00000012, wdata 0x0000BEEF -> `bus_be`=1100, `bus_wdata`=0xBEEFBEEF, `bus_addr`=0x00000010, `bus_we`=1.
- lw with ack delayed 5 cycles -> `bus_req` high for 6 cycles, bus_* constant throughout, `rdata`=`bus_rdata`, latency 7.
- No ack for TIMEOUT=15 cycles -> `timeout_err`=1 (stays set), `rdata`=0, `done` pulse, next request still serviced.
- Both MemRead=11 and MemWrite=11 -> a store is performed with `bus_we`=1. With `DMEM_MISALIGN_TRAP_EN` defined, lw at 0x00000002 -> no `bus_req`, `misalign`+`done` after 1 cycle.
- `rst_n` low during REQ -> `bus_req`=0 immediately, all outputs 0. After release, a fresh lb completes normally.

Source files
------------

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: data-memory access sequencer between execute and the word-wide data bus.
// Latches a load or store, runs one req/ack bus transaction, and steers byte lanes.
// It sign-extends load data and stalls the pipeline until the access completes.
// A bus cycle that waits TIMEOUT cycles without ack is aborted, and a sticky timeout_err is raised.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN. When it is defined, misaligned half/word
// accesses skip the bus and complete in one cycle with a misalign pulse.
module dmem_access_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  MemRead,
    input  logic [1:0]  MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        misalign,
    output logic        timeout_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  lane_q, lane_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        terr_q, terr_d;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        mis_q, mis_d;
`endif

    logic        req_valid;
    logic [1:0]  req_size;

    // Byte enables for the access size at byte offset k
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] k);
        case (size)
            2'b01:   return 4'b0001 << k;
            2'b10:   return k[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate store data across all lanes so the enabled lanes carry it
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b01:   return {4{d[7:0]}};
            2'b10:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Select the addressed byte/half of the bus word and sign-extend it
    function automatic logic [31:0] load_ext(input logic [1:0] size, input logic [1:0] k,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (k)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = k[1] ? d[31:16] : d[15:0];
        case (size)
            2'b01:   return {{24{b[7]}}, b};
            2'b10:   return {{16{h[15]}}, h};
            default: return d;
        endcase
    endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
    // Half needs an even address, word needs a word-aligned address
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] k);
        return ((size == 2'b10) && k[0]) || ((size == 2'b11) && (k != 2'b00));
    endfunction
`endif

    assign req_valid = (MemWrite != 2'b00) || (MemRead != 2'b00);
    assign req_size  = (MemWrite != 2'b00) ? MemWrite : MemRead;

    // Next-state logic: accept a request, run the bus cycle, and complete or abort it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        lane_d  = lane_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        terr_d  = terr_q;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
`ifdef DMEM_MISALIGN_TRAP_EN
                    if (is_misaligned(req_size, addr[1:0])) begin
                        mis_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
`endif
                        size_d  = req_size;
                        lane_d  = addr[1:0];
                        we_d    = (MemWrite != 2'b00);
                        addr_d  = {addr[31:2], 2'b00};
                        be_d    = lane_be(req_size, addr[1:0]);
                        wdata_d = lane_wdata(req_size, wdata);
                        cnt_d   = 8'd0;
                        state_d = S_REQ;
`ifdef DMEM_MISALIGN_TRAP_EN
                    end
`endif
                end
            end
            S_REQ: begin
                if (bus_ack) begin
                    if (!we_q) rdata_d = load_ext(size_q, lane_q, bus_rdata);
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
                        terr_d  = 1'b1;
                        rdata_d = 32'd0;
                        state_d = S_ERR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any bus cycle and clears all outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            size_q  <= 2'b00;
            lane_q  <= 2'b00;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            terr_q  <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            lane_q  <= lane_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            terr_q  <= terr_d;
`ifdef DMEM_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    assign bus_req     = (state_q == S_REQ);
    assign stall       = ((state_q == S_IDLE) && req_valid) || (state_q == S_REQ);
    assign done        = (state_q == S_DONE) || (state_q == S_ERR);
    assign bus_we      = we_q;
    assign bus_addr    = addr_q;
    assign bus_be      = be_q;
    assign bus_wdata   = wdata_q;
    assign rdata       = rdata_q;
    assign timeout_err = terr_q;
`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign    = mis_q;
`else
    assign misalign    = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: reset, lane steering, wait states, timeout,
// write priority, misaligned access, back-to-back requests, and reset during a bus cycle.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  MemRead, MemWrite;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        stall, done, misalign, timeout_err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    dmem_access_unit #(.TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .done(done),
        .misalign(misalign), .timeout_err(timeout_err), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        MemRead = 2'b00; MemWrite = 2'b00; bus_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; clear_inputs(); addr = 32'd0; wdata = 32'd0; bus_rdata = 32'd0;
        #3;
        total++; if ({bus_req, bus_we, stall, done, misalign, timeout_err} !== 6'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=000000", {bus_req, bus_we, stall, done, misalign, timeout_err}); end
        total++; if ({rdata, bus_addr, bus_wdata, bus_be} !== 100'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", {rdata, bus_addr, bus_wdata, bus_be}); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lb;
        MemRead = 2'b01; addr = 32'h0000_0103; bus_rdata = 32'h80FF_1234; bus_ack = 1'b1;
        #1;
        total++; if ({stall, bus_req} !== 2'b10) begin bad++; $display("FAIL lb_idle stall/req got=%b exp=10", {stall, bus_req}); end
        tick();
        total++; if ({stall, bus_req, bus_we} !== 3'b110) begin bad++; $display("FAIL lb_req stall/req/we got=%b exp=110", {stall, bus_req, bus_we}); end
        total++; if ({bus_addr, bus_be} !== {32'h0000_0100, 4'b1000}) begin bad++; $display("FAIL lb_bus addr/be got=%h/%b exp=00000100/1000", bus_addr, bus_be); end
        tick();
        total++; if ({done, stall, bus_req} !== 3'b100) begin bad++; $display("FAIL lb_done done/stall/req got=%b exp=100", {done, stall, bus_req}); end
        total++; if (rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_rdata got=%h exp=ffffff80", rdata); end
        clear_inputs();
        tick();
        total++; if ({done, stall} !== 2'b00) begin bad++; $display("FAIL lb_after done/stall got=%b exp=00", {done, stall}); end
    endtask

    task automatic test_sh;
        MemWrite = 2'b10; addr = 32'h0000_0012; wdata = 32'h0000_BEEF;
        tick();
        total++; if ({bus_req, bus_we, bus_be} !== 6'b11_1100) begin bad++; $display("FAIL sh_ctl req/we/be got=%b exp=111100", {bus_req, bus_we, bus_be}); end
        total++; if ({bus_addr, bus_wdata} !== {32'h0000_0010, 32'hBEEF_BEEF}) begin bad++; $display("FAIL sh_bus addr/wdata got=%h/%h exp=00000010/beefbeef", bus_addr, bus_wdata); end
        bus_ack = 1'b1;
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL sh_done got=%b exp=1", done); end
        total++; if (rdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL sh_rdata_kept got=%h exp=ffffff80", rdata); end
        clear_inputs();
        tick();
    endtask

    task automatic test_lw_wait;
        int cycles;
        int reqcyc;
        logic held_ok;
        MemRead = 2'b11; addr = 32'h0000_0020; bus_rdata = 32'h0BAD_0BAD; held_ok = 1'b1;
        cycles = 1; reqcyc = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (bus_req) reqcyc++;
            if (done || bus_addr !== 32'h0000_0020 || bus_be !== 4'b1111 || bus_we !== 1'b0) held_ok = 1'b0;
            cycles++;
            tick();
        end
        if (bus_req) reqcyc++;
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        cycles++;
        tick();
        total++; if (held_ok !== 1'b1) begin bad++; $display("FAIL lw_wait_held got=%b exp=1", held_ok); end
        total++; if (reqcyc !== 6) begin bad++; $display("FAIL lw_wait_req_cycles got=%0d exp=6", reqcyc); end
        total++; if (cycles !== 7 || done !== 1'b1) begin bad++; $display("FAIL lw_wait_latency got=%0d/done=%b exp=7/1", cycles, done); end
        total++; if (rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL lw_wait_rdata got=%h exp=cafef00d", rdata); end
        clear_inputs();
        tick();
    endtask

    task automatic test_ack_at_limit;
        MemRead = 2'b10; addr = 32'h0000_0002; bus_rdata = 32'h8001_7FFF;
        tick();
        for (int i = 0; i < 14; i++) tick();
        total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL limit_req15 got=%b exp=1", bus_req); end
        bus_ack = 1'b1;
        tick();
        total++; if ({done, timeout_err} !== 2'b10) begin bad++; $display("FAIL limit_done/terr got=%b exp=10", {done, timeout_err}); end
        total++; if (rdata !== 32'hFFFF_8001) begin bad++; $display("FAIL limit_rdata got=%h exp=ffff8001", rdata); end
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout;
        int n;
        MemRead = 2'b01; addr = 32'h0000_0000;
        n = 0;
        tick();
        while (bus_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        total++; if (n !== 15) begin bad++; $display("FAIL to_req_cycles got=%0d exp=15", n); end
        total++; if ({done, timeout_err, stall, bus_req} !== 4'b1100) begin bad++; $display("FAIL to_err done/terr/stall/req got=%b exp=1100", {done, timeout_err, stall, bus_req}); end
        total++; if (rdata !== 32'd0) begin bad++; $display("FAIL to_rdata got=%h exp=00000000", rdata); end
        clear_inputs();
        tick();
        total++; if ({done, timeout_err} !== 2'b01) begin bad++; $display("FAIL to_sticky done/terr got=%b exp=01", {done, timeout_err}); end
        MemRead = 2'b01; addr = 32'h0000_0001; bus_rdata = 32'h0000_7F00; bus_ack = 1'b1;
        tick(); tick();
        total++; if ({done, timeout_err} !== 2'b11) begin bad++; $display("FAIL to_next done/terr got=%b exp=11", {done, timeout_err}); end
        total++; if (rdata !== 32'h0000_007F) begin bad++; $display("FAIL to_next_rdata got=%h exp=0000007f", rdata); end
        clear_inputs();
        tick();
    endtask

    task automatic test_both_codes;
        MemRead = 2'b11; MemWrite = 2'b11; addr = 32'h0000_0040; wdata = 32'h1122_3344;
        tick();
        total++; if ({bus_req, bus_we, bus_be} !== 6'b11_1111) begin bad++; $display("FAIL both_ctl req/we/be got=%b exp=111111", {bus_req, bus_we, bus_be}); end
        total++; if (bus_wdata !== 32'h1122_3344) begin bad++; $display("FAIL both_wdata got=%h exp=11223344", bus_wdata); end
        bus_ack = 1'b1;
        tick();
        total++; if ({done, rdata} !== {1'b1, 32'h0000_007F}) begin bad++; $display("FAIL both_done done/rdata got=%b/%h exp=1/0000007f", done, rdata); end
        clear_inputs();
        tick();
    endtask

    task automatic test_misalign;
        MemRead = 2'b11; addr = 32'h0000_0002; bus_rdata = 32'h0BAD_F00D;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL mis_idle_stall got=%b exp=1", stall); end
        tick();
`ifdef DMEM_MISALIGN_TRAP_EN
        total++; if ({done, misalign, bus_req, stall} !== 4'b1100) begin bad++; $display("FAIL mis_trap done/mis/req/stall got=%b exp=1100", {done, misalign, bus_req, stall}); end
        total++; if (rdata !== 32'h0000_007F) begin bad++; $display("FAIL mis_trap_rdata got=%h exp=0000007f", rdata); end
        clear_inputs();
        tick();
        total++; if ({done, misalign} !== 2'b00) begin bad++; $display("FAIL mis_trap_after got=%b exp=00", {done, misalign}); end
`else
        total++; if ({bus_req, bus_be, bus_addr} !== {1'b1, 4'b1111, 32'h0}) begin bad++; $display("FAIL mis_bus req/be/addr got=%b/%b/%h exp=1/1111/00000000", bus_req, bus_be, bus_addr); end
        bus_ack = 1'b1;
        tick();
        total++; if ({done, misalign} !== 2'b10) begin bad++; $display("FAIL mis_done done/mis got=%b exp=10", {done, misalign}); end
        total++; if (rdata !== 32'h0BAD_F00D) begin bad++; $display("FAIL mis_rdata got=%h exp=0badf00d", rdata); end
        clear_inputs();
        tick();
`endif
    endtask

    task automatic test_back_to_back;
        MemWrite = 2'b01; addr = 32'h0000_0005; wdata = 32'h0000_00A5; bus_ack = 1'b1;
        tick();
        total++; if ({bus_req, bus_be, bus_wdata} !== {1'b1, 4'b0010, 32'hA5A5_A5A5}) begin bad++; $display("FAIL b2b_first req/be/wdata got=%b/%b/%h exp=1/0010/a5a5a5a5", bus_req, bus_be, bus_wdata); end
        tick();
        total++; if ({done, bus_req, stall} !== 3'b100) begin bad++; $display("FAIL b2b_done done/req/stall got=%b exp=100", {done, bus_req, stall}); end
        addr = 32'h0000_0006;
        tick();
        total++; if ({done, bus_req, stall} !== 3'b001) begin bad++; $display("FAIL b2b_idle done/req/stall got=%b exp=001", {done, bus_req, stall}); end
        tick();
        total++; if ({bus_req, bus_be} !== 5'b1_0100) begin bad++; $display("FAIL b2b_second req/be got=%b exp=10100", {bus_req, bus_be}); end
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_second_done got=%b exp=1", done); end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_req;
        MemRead = 2'b01; addr = 32'h0000_0003;
        tick();
        total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL rst_pre_req got=%b exp=1", bus_req); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({bus_req, stall, done, timeout_err, bus_we} !== 5'b01000) begin bad++; $display("FAIL rst_async req/stall/done/terr/we got=%b exp=01000", {bus_req, stall, done, timeout_err, bus_we}); end
        total++; if ({rdata, bus_addr, bus_wdata, bus_be} !== 100'd0) begin bad++; $display("FAIL rst_async_data got=%h exp=0", {rdata, bus_addr, bus_wdata, bus_be}); end
        clear_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        MemRead = 2'b01; addr = 32'h0000_0000; bus_rdata = 32'h0000_00FE; bus_ack = 1'b1;
        tick();
        total++; if ({bus_req, bus_be} !== 5'b1_0001) begin bad++; $display("FAIL rst_fresh_req req/be got=%b exp=10001", {bus_req, bus_be}); end
        tick();
        total++; if ({done, timeout_err, rdata} !== {2'b10, 32'hFFFF_FFFE}) begin bad++; $display("FAIL rst_fresh_done done/terr/rdata got=%b/%b/%h exp=1/0/fffffffe", done, timeout_err, rdata); end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sh();
        test_lw_wait();
        test_ack_at_limit();
        test_timeout();
        test_both_codes();
        test_misalign();
        test_back_to_back();
        test_reset_mid_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
